// File: rtl/axi4_read_dma_master.sv
// AXI4 read DMA master.
// A command (start address, beat count) is split into INCR bursts. No burst crosses a 4 KB
// boundary or exceeds MAX_BURST_LEN_P beats. Only one burst is outstanding at a time. R beats
// pass straight through to a ready/valid output stream.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_*                 command input (addr, beats, valid/ready)
//   mst_ar*               AXI4 read-address channel
//   mst_r*                AXI4 read-data channel
//   dout_*                output data stream (data, last, valid/ready)
//   busy, done, err       status: not idle, end-of-command pulse, sticky error
module axi4_read_dma_master #(
  parameter int unsigned AXI_ID_WIDTH_P   = 4,
  parameter int unsigned AXI_ADDR_WIDTH_P = 32,
  parameter int unsigned AXI_DATA_WIDTH_P = 64,
  parameter int unsigned AXI_ID_P         = 0,
  parameter int unsigned MAX_BURST_LEN_P  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH_P-1:0] cmd_addr,
  input  logic [15:0]                 cmd_beats,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic [AXI_ID_WIDTH_P-1:0]   mst_arid,
  output logic [AXI_ADDR_WIDTH_P-1:0] mst_araddr,
  output logic [7:0]                  mst_arlen,
  output logic [2:0]                  mst_arsize,
  output logic [1:0]                  mst_arburst,
  output logic [3:0]                  mst_arregion,
  output logic                        mst_arvalid,
  input  logic                        mst_arready,
  input  logic [AXI_ID_WIDTH_P-1:0]   mst_rid,
  input  logic [1:0]                  mst_rresp,
  input  logic [AXI_DATA_WIDTH_P-1:0] mst_rdata,
  input  logic                        mst_rlast,
  input  logic                        mst_rvalid,
  output logic                        mst_rready,
  output logic [AXI_DATA_WIDTH_P-1:0] dout_data,
  output logic                        dout_last,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned Bytes = AXI_DATA_WIDTH_P / 8;
  localparam int unsigned SizeW = $clog2(Bytes);
  localparam logic [AXI_ADDR_WIDTH_P-1:0] AlignMask = ~(AXI_ADDR_WIDTH_P'(Bytes - 1));

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH_P-1:0] araddr_q, araddr_d;
  logic [7:0]                  arlen_q, arlen_d;
  logic [15:0]                 rem_q, rem_d;     // beats still to request after current burst
  logic [7:0]                  cnt_q, cnt_d;     // beats accepted in current burst
  logic                        err_q, err_d;

  logic [AXI_ADDR_WIDTH_P-1:0] cmd_addr_al, next_addr;
  logic [8:0]                  beats;
  logic                        in_data, beat_fire, burst_end;

  // Beats for a burst starting at aligned address a with rem beats left.
  function automatic logic [8:0] burst_beats(input logic [AXI_ADDR_WIDTH_P-1:0] a,
                                             input logic [15:0] rem);
    logic [12:0] room;
    logic [16:0] b;
    room = (13'd4096 - {1'b0, a[11:0]}) >> SizeW;
    b = {1'b0, rem};
    if (b > 17'(MAX_BURST_LEN_P)) b = 17'(MAX_BURST_LEN_P);
    if (b > {4'b0, room}) b = {4'b0, room};
    return b[8:0];
  endfunction

  assign cmd_addr_al = cmd_addr & AlignMask;
  assign next_addr   = araddr_q + ((AXI_ADDR_WIDTH_P'(arlen_q) + 1'b1) << SizeW);
  assign in_data     = (state_q == StData);
  assign beat_fire   = in_data && mst_rvalid && dout_ready;
  assign burst_end   = (cnt_q == arlen_q);

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    beats    = 9'd0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          if (cmd_beats == 16'd0) begin
            state_d = StDone;
          end else begin
            beats    = burst_beats(cmd_addr_al, cmd_beats);
            araddr_d = cmd_addr_al;
            arlen_d  = 8'(beats - 9'd1);
            rem_d    = cmd_beats - 16'(beats);
            cnt_d    = 8'd0;
            state_d  = StAddr;
          end
        end
      end
      StAddr: begin
        if (mst_arready) state_d = StData;
      end
      StData: begin
        if (beat_fire) begin
          cnt_d = cnt_q + 8'd1;
          // Burst end follows the local count; a disagreeing rlast only flags an error.
          if (mst_rresp != 2'b00 || mst_rlast != burst_end) err_d = 1'b1;
          if (burst_end) begin
            if (rem_q != 16'd0) begin
              beats    = burst_beats(next_addr, rem_q);
              araddr_d = next_addr;
              arlen_d  = 8'(beats - 9'd1);
              rem_d    = rem_q - 16'(beats);
              cnt_d    = 8'd0;
              state_d  = StAddr;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      araddr_q <= '0;
      arlen_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign err          = err_q;

  assign mst_arid     = AXI_ID_WIDTH_P'(AXI_ID_P);
  assign mst_araddr   = araddr_q;
  assign mst_arlen    = arlen_q;
  assign mst_arsize   = 3'(SizeW);
  assign mst_arburst  = 2'b01;
  assign mst_arregion = 4'h0;
  assign mst_arvalid  = (state_q == StAddr);

  assign mst_rready   = in_data && dout_ready;
  assign dout_valid   = in_data && mst_rvalid;
  assign dout_data    = mst_rdata;
  assign dout_last    = in_data && burst_end && (rem_q == 16'd0);

  logic unused_rid;
  assign unused_rid = ^mst_rid;

endmodule
